// File: rtl/ce_monitor_if.sv
`default_nettype none
// ============================================================================
// Module      : ce_monitor_if
// Description : Strobe inputs, clear request and status outputs of the
//               clock-enable monitor. FAULT_CNT_W must match the monitor's
//               own FAULT_CNT_W parameter.
// Revision    : 1.0 - initial release
// ============================================================================
interface ce_monitor_if #(
    parameter int FAULT_CNT_W = 8
) ();
    logic                   ce_16d384M;
    logic                   ce_2d048M;
    logic                   ce_1d024M;
    logic                   err_clr;
    logic                   clk_ok;
    logic [2:0]             err_period;
    logic                   err_align;
    logic [FAULT_CNT_W-1:0] fault_cnt;
    logic [1:0]             state;

    // Strobe source / status consumer side
    modport master (
        output ce_16d384M, ce_2d048M, ce_1d024M, err_clr,
        input  clk_ok, err_period, err_align, fault_cnt, state
    );

    // Monitor side
    modport slave (
        input  ce_16d384M, ce_2d048M, ce_1d024M, err_clr,
        output clk_ok, err_period, err_align, fault_cnt, state
    );
endinterface
`default_nettype wire

// File: rtl/ce_monitor.sv
`default_nettype none
// ============================================================================
// Module      : ce_monitor
// Description : Watches the 16.384/2.048/1.024 MHz clock-enable strobes of a
//               32.768 MHz domain, checks their periods and mutual alignment,
//               and declares lock after LOCK_PERIODS clean 1.024 MHz periods.
// Revision    : 1.0 - initial release
// ============================================================================
module ce_monitor #(
    parameter int LOCK_PERIODS = 16,
    parameter int FAULT_CNT_W  = 8
) (
    input  wire logic   clk_32d768M,
    input  wire logic   rst_n_32d768M,
    ce_monitor_if.slave bus
);

    typedef enum logic [1:0] {
        ST_ACQUIRE = 2'd0,
        ST_LOCKING = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_FAULT   = 2'd3
    } state_t;

    localparam logic [5:0]             c_cnt_max   = 6'd63;
    localparam logic [7:0]             c_lock_last = 8'(LOCK_PERIODS - 1);
    localparam logic [FAULT_CNT_W-1:0] c_fault_one = FAULT_CNT_W'(1);
    localparam logic [FAULT_CNT_W-1:0] c_fault_max = '1;

    state_t                 r_state;
    logic [7:0]             r_good_cnt;
    logic [2:0]             r_armed;
    logic                   r_clk_ok;
    logic [2:0]             r_err_period;
    logic                   r_err_align;
    logic [FAULT_CNT_W-1:0] r_fault_cnt;

    logic [2:0] w_strobe;
    logic [2:0] w_perr;
    logic       w_aerr;
    logic       w_active;
    logic       w_fault;

    // Bit order matches err_period: 0 = 16.384M, 1 = 2.048M, 2 = 1.024M
    assign w_strobe = {bus.ce_1d024M, bus.ce_2d048M, bus.ce_16d384M};

    // Per-channel cycles-since-strobe counter and period check
    for (genvar i = 0; i < 3; i++) begin : g_chan
        localparam logic [5:0] c_last = (i == 0) ? 6'd1 : (i == 1) ? 6'd15 : 6'd31;
        logic [5:0] r_cnt;

        // Restart on every strobe, otherwise count up and stick at the top
        always_ff @(posedge clk_32d768M or negedge rst_n_32d768M) begin
            if (!rst_n_32d768M) begin
                r_cnt <= '0;
            end else if (w_strobe[i]) begin
                r_cnt <= '0;
            end else if (r_cnt != c_cnt_max) begin
                r_cnt <= r_cnt + 6'd1;
            end
        end

        // Strobe off its slot (early/double) or slot reached with no strobe
        assign w_perr[i] = r_armed[i] &&
                           (w_strobe[i] ? (r_cnt != c_last) : (r_cnt == c_last));
    end

    // Slower strobes must always coincide with every faster one
    assign w_aerr = (bus.ce_1d024M && !(bus.ce_2d048M && bus.ce_16d384M)) ||
                    (bus.ce_2d048M && !bus.ce_16d384M);

    // Errors only count while acquiring or holding lock
    assign w_active = (r_state == ST_LOCKING) || (r_state == ST_LOCKED);
    assign w_fault  = w_active && ((|w_perr) || w_aerr);

    // Lock state machine: acquire on a common strobe, count clean periods
    always_ff @(posedge clk_32d768M or negedge rst_n_32d768M) begin
        if (!rst_n_32d768M) begin
            r_state    <= ST_ACQUIRE;
            r_good_cnt <= '0;
            r_armed    <= '0;
            r_clk_ok   <= 1'b0;
        end else begin
            case (r_state)
                ST_ACQUIRE: begin
                    if (&w_strobe) begin
                        r_state    <= ST_LOCKING;
                        r_good_cnt <= '0;
                        r_armed    <= 3'b111;
                    end
                end
                ST_LOCKING: begin
                    // An error in the completing period beats the lock
                    if (w_fault) begin
                        r_state <= ST_FAULT;
                    end else if (bus.ce_1d024M) begin
                        r_good_cnt <= r_good_cnt + 8'd1;
                        if (r_good_cnt == c_lock_last) begin
                            r_state  <= ST_LOCKED;
                            r_clk_ok <= 1'b1;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (w_fault) begin
                        r_state  <= ST_FAULT;
                        r_clk_ok <= 1'b0;
                    end
                end
                ST_FAULT: begin
                    r_state <= ST_ACQUIRE;
                    r_armed <= 3'b000;
                end
                default: begin
                    r_state <= ST_ACQUIRE;
                end
            endcase
        end
    end

    // Sticky error bits and fault counter; a new fault outranks a clear
    always_ff @(posedge clk_32d768M or negedge rst_n_32d768M) begin
        if (!rst_n_32d768M) begin
            r_err_period <= '0;
            r_err_align  <= 1'b0;
            r_fault_cnt  <= '0;
        end else if (w_fault) begin
            r_err_period <= (bus.err_clr ? 3'b000 : r_err_period) | w_perr;
            r_err_align  <= (bus.err_clr ? 1'b0 : r_err_align) | w_aerr;
            if (bus.err_clr) begin
                r_fault_cnt <= c_fault_one;
            end else if (r_fault_cnt != c_fault_max) begin
                r_fault_cnt <= r_fault_cnt + c_fault_one;
            end
        end else if (bus.err_clr) begin
            r_err_period <= '0;
            r_err_align  <= 1'b0;
            r_fault_cnt  <= '0;
        end
    end

    assign bus.clk_ok     = r_clk_ok;
    assign bus.err_period = r_err_period;
    assign bus.err_align  = r_err_align;
    assign bus.fault_cnt  = r_fault_cnt;
    assign bus.state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_ce_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_ce_monitor
// Description : Self-checking bench for ce_monitor. Two instances share the
//               strobes: A (LOCK_PERIODS=16, 8-bit counter) and B
//               (LOCK_PERIODS=1, 2-bit counter, so it locks and saturates
//               quickly). A cycle-level reference model tracks time since
//               each strobe and the lock mode of both instances.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ce_monitor;

    localparam int M_ACQ     = 0;
    localparam int M_LOCKING = 1;
    localparam int M_LOCKED  = 2;
    localparam int M_FAULT   = 3;
    localparam int PERIOD [3] = '{2, 16, 32};
    localparam int LP     [2] = '{16, 1};
    localparam int FMAX   [2] = '{255, 3};

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic s16   = 1'b0;
    logic s2    = 1'b0;
    logic s1    = 1'b0;
    logic clr   = 1'b0;

    int checks   = 0;
    int failures = 0;
    int ph       = 27;

    // Reference model state
    longint cyc = 0;
    longint m_last [3];
    int       m_mode   [2];
    int       m_good   [2];
    int       m_faults [2];
    bit [2:0] m_sp     [2];
    bit       m_sa     [2];

    always #5 clk = ~clk;

    ce_monitor_if #(.FAULT_CNT_W(8)) bus_a ();
    ce_monitor_if #(.FAULT_CNT_W(2)) bus_b ();

    assign bus_a.ce_16d384M = s16;
    assign bus_a.ce_2d048M  = s2;
    assign bus_a.ce_1d024M  = s1;
    assign bus_a.err_clr    = clr;
    assign bus_b.ce_16d384M = s16;
    assign bus_b.ce_2d048M  = s2;
    assign bus_b.ce_1d024M  = s1;
    assign bus_b.err_clr    = clr;

    ce_monitor #(.LOCK_PERIODS(16), .FAULT_CNT_W(8)) dut_a (
        .clk_32d768M   (clk),
        .rst_n_32d768M (rst_n),
        .bus           (bus_a.slave)
    );

    ce_monitor #(.LOCK_PERIODS(1), .FAULT_CNT_W(2)) dut_b (
        .clk_32d768M   (clk),
        .rst_n_32d768M (rst_n),
        .bus           (bus_b.slave)
    );

    // Packed view {state, clk_ok, err_period, err_align, fault_cnt[7:0]}
    function automatic logic [14:0] obs(input int k);
        if (k == 0)
            return {bus_a.state, bus_a.clk_ok, bus_a.err_period, bus_a.err_align, bus_a.fault_cnt};
        return {bus_b.state, bus_b.clk_ok, bus_b.err_period, bus_b.err_align, 6'b0, bus_b.fault_cnt};
    endfunction

    function automatic logic [14:0] mdl(input int k);
        return {2'(m_mode[k]), (m_mode[k] == M_LOCKED), m_sp[k], m_sa[k], 8'(m_faults[k])};
    endfunction

    // Ideal divider output for a phase 0..31 of the 1.024 MHz period
    function automatic bit [2:0] ideal(input int p);
        return {p == 0, (p % 16) == 0, (p % 2) == 0};
    endfunction

    task automatic model_reset();
        for (int ch = 0; ch < 3; ch++) m_last[ch] = cyc - 1;
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = M_ACQ; m_good[k] = 0; m_faults[k] = 0;
            m_sp[k] = 3'b000; m_sa[k] = 1'b0;
        end
    endtask

    task automatic model_step(input bit [2:0] s, input bit c);
        bit [2:0] pe;
        bit       ae;
        bit       err;
        bit       active;
        longint   gap;
        ae = (s[2] && !(s[1] && s[0])) || (s[1] && !s[0]);
        pe = 3'b000;
        for (int ch = 0; ch < 3; ch++) begin
            gap = cyc - m_last[ch] - 1;
            pe[ch] = s[ch] ? (gap != longint'(PERIOD[ch] - 1)) : (gap == longint'(PERIOD[ch] - 1));
        end
        for (int k = 0; k < 2; k++) begin
            active = (m_mode[k] == M_LOCKING) || (m_mode[k] == M_LOCKED);
            err = active && ((pe != 3'b000) || ae);
            if (c) begin
                m_sp[k] = 3'b000; m_sa[k] = 1'b0; m_faults[k] = 0;
            end
            if (err) begin
                m_sp[k] = m_sp[k] | pe;
                m_sa[k] = m_sa[k] | ae;
                if (m_faults[k] < FMAX[k]) m_faults[k]++;
            end
            case (m_mode[k])
                M_ACQ: if (s == 3'b111) begin m_mode[k] = M_LOCKING; m_good[k] = 0; end
                M_LOCKING: begin
                    if (err) m_mode[k] = M_FAULT;
                    else if (s[2]) begin
                        m_good[k]++;
                        if (m_good[k] >= LP[k]) m_mode[k] = M_LOCKED;
                    end
                end
                M_LOCKED: if (err) m_mode[k] = M_FAULT;
                default: m_mode[k] = M_ACQ;
            endcase
        end
        for (int ch = 0; ch < 3; ch++) if (s[ch]) m_last[ch] = cyc;
        cyc++;
    endtask

    // Called at a falling edge; returns at the next falling edge
    task automatic tick(input bit [2:0] s, input bit c);
        s16 = s[0]; s2 = s[1]; s1 = s[2]; clr = c;
        @(posedge clk);
        model_step(s, c);
        @(negedge clk);
    endtask

    // One ideal cycle with selected strobe bits inverted
    task automatic ideal_tick(input bit [2:0] flip, input bit c);
        tick(ideal(ph) ^ flip, c);
        ph = (ph + 1) % 32;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs(0) !== 15'h0) begin
            $display("FAIL reset_a: got %h expected %h", obs(0), 15'h0); failures++;
        end
        checks++;
        if (obs(1) !== 15'h0) begin
            $display("FAIL reset_b: got %h expected %h", obs(1), 15'h0); failures++;
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_ideal_lock();
        while (ph != 0) ideal_tick(3'b000, 1'b0);
        checks++;
        if (bus_a.state !== 2'd0) begin
            $display("FAIL pre_common_state: got %0d expected 0", bus_a.state); failures++;
        end
        ideal_tick(3'b000, 1'b0);
        checks++;
        if (bus_a.state !== 2'd1) begin
            $display("FAIL common_strobe_state: got %0d expected 1", bus_a.state); failures++;
        end
        repeat (511) ideal_tick(3'b000, 1'b0);
        checks++;
        if ({bus_a.state, bus_a.clk_ok} !== {2'd1, 1'b0}) begin
            $display("FAIL before_16th_strobe: got state=%0d clk_ok=%0b expected 1/0",
                     bus_a.state, bus_a.clk_ok); failures++;
        end
        ideal_tick(3'b000, 1'b0);
        checks++;
        if (obs(0) !== {2'd2, 1'b1, 3'b000, 1'b0, 8'd0}) begin
            $display("FAIL locked_a: got %h expected %h", obs(0), {2'd2, 1'b1, 3'b000, 1'b0, 8'd0});
            failures++;
        end
        checks++;
        if (obs(1) !== mdl(1)) begin
            $display("FAIL locked_b: got %h expected %h", obs(1), mdl(1)); failures++;
        end
    endtask

    task automatic test_drop_2m();
        int n;
        while (ph != 16) ideal_tick(3'b000, 1'b0);
        ideal_tick(3'b010, 1'b0);
        checks++;
        if (obs(0) !== {2'd3, 1'b0, 3'b010, 1'b0, 8'd1}) begin
            $display("FAIL drop2m_fault: got %h expected %h", obs(0), {2'd3, 1'b0, 3'b010, 1'b0, 8'd1});
            failures++;
        end
        ideal_tick(3'b000, 1'b0);
        checks++;
        if (bus_a.state !== 2'd0) begin
            $display("FAIL drop2m_acquire: got %0d expected 0", bus_a.state); failures++;
        end
        n = 0;
        while (!bus_a.clk_ok && n < 2000) begin
            ideal_tick(3'b000, 1'b0);
            n++;
        end
        checks++;
        if (!bus_a.clk_ok || (n + 2) < 512) begin
            $display("FAIL drop2m_relock: got clk_ok=%0b low_cycles=%0d expected 1 and >=512",
                     bus_a.clk_ok, n + 2); failures++;
        end
        checks++;
        if (obs(0) !== mdl(0) || obs(1) !== mdl(1)) begin
            $display("FAIL drop2m_model: got %h/%h expected %h/%h", obs(0), obs(1), mdl(0), mdl(1));
            failures++;
        end
    endtask

    task automatic test_align();
        ideal_tick(3'b000, 1'b1);
        checks++;
        if (obs(0) !== {2'd2, 1'b1, 3'b000, 1'b0, 8'd0}) begin
            $display("FAIL lone_clear: got %h expected %h", obs(0), {2'd2, 1'b1, 3'b000, 1'b0, 8'd0});
            failures++;
        end
        while (ph != 30) ideal_tick(3'b000, 1'b0);
        ideal_tick(3'b100, 1'b0);
        checks++;
        if (obs(0) !== {2'd3, 1'b0, 3'b100, 1'b1, 8'd1}) begin
            $display("FAIL align_fault: got %h expected %h", obs(0), {2'd3, 1'b0, 3'b100, 1'b1, 8'd1});
            failures++;
        end
        ideal_tick(3'b000, 1'b0);
        ideal_tick(3'b100, 1'b0);
        checks++;
        if (bus_a.state !== 2'd0) begin
            $display("FAIL no_common_stays_acquire: got %0d expected 0", bus_a.state); failures++;
        end
        checks++;
        if (obs(1) !== mdl(1)) begin
            $display("FAIL align_b: got %h expected %h", obs(1), mdl(1)); failures++;
        end
    endtask

    task automatic test_clr_collision();
        int n;
        n = 0;
        while (!bus_a.clk_ok && n < 2000) begin
            ideal_tick(3'b000, 1'b0);
            n++;
        end
        checks++;
        if (!bus_a.clk_ok) begin
            $display("FAIL collision_relock: got clk_ok=0 expected 1 within 2000 cycles"); failures++;
        end
        while (ph != 5) ideal_tick(3'b000, 1'b0);
        ideal_tick(3'b001, 1'b1);
        checks++;
        if (obs(0) !== {2'd3, 1'b0, 3'b001, 1'b0, 8'd1}) begin
            $display("FAIL clr_collision: got %h expected %h", obs(0), {2'd3, 1'b0, 3'b001, 1'b0, 8'd1});
            failures++;
        end
        repeat (4) ideal_tick(3'b000, 1'b0);
        ideal_tick(3'b000, 1'b1);
        checks++;
        if ({bus_a.err_period, bus_a.err_align, bus_a.fault_cnt} !== 12'h0) begin
            $display("FAIL later_clear: got %h expected 000",
                     {bus_a.err_period, bus_a.err_align, bus_a.fault_cnt}); failures++;
        end
        checks++;
        if (obs(0) !== mdl(0) || obs(1) !== mdl(1)) begin
            $display("FAIL clear_model: got %h/%h expected %h/%h", obs(0), obs(1), mdl(0), mdl(1));
            failures++;
        end
    endtask

    task automatic test_saturation();
        int n;
        for (int f = 0; f < 5; f++) begin
            n = 0;
            while (!bus_b.clk_ok && n < 200) begin
                ideal_tick(3'b000, 1'b0);
                n++;
            end
            checks++;
            if (!bus_b.clk_ok) begin
                $display("FAIL sat_relock_%0d: got clk_ok=0 expected 1 within 200 cycles", f); failures++;
            end
            if (ph % 2 == 0) ideal_tick(3'b000, 1'b0);
            ideal_tick(3'b001, 1'b0);
            checks++;
            if (obs(1) !== mdl(1)) begin
                $display("FAIL sat_fault_%0d: got %h expected %h", f, obs(1), mdl(1)); failures++;
            end
        end
        checks++;
        if (bus_b.fault_cnt !== 2'd3) begin
            $display("FAIL fault_saturation: got %0d expected 3", bus_b.fault_cnt); failures++;
        end
        checks++;
        if (obs(0) !== mdl(0)) begin
            $display("FAIL sat_a: got %h expected %h", obs(0), mdl(0)); failures++;
        end
    endtask

    task automatic test_random();
        bit [2:0] flip;
        bit       c;
        for (int i = 0; i < 3000; i++) begin
            flip = 3'b000;
            if ($urandom_range(0, 399) == 0) flip[$urandom_range(0, 2)] = 1'b1;
            c = ($urandom_range(0, 149) == 0);
            ideal_tick(flip, c);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs(k) !== mdl(k)) begin
                    $display("FAIL random_%0d_cycle_%0d: got %h expected %h", k, i, obs(k), mdl(k));
                    failures++;
                end
            end
        end
    endtask

    task automatic test_reset_mid_locked();
        int n;
        n = 0;
        while (!bus_a.clk_ok && n < 1500) begin
            ideal_tick(3'b000, 1'b0);
            n++;
        end
        ideal_tick(3'b000, 1'b1);
        checks++;
        if (obs(0) !== {2'd2, 1'b1, 3'b000, 1'b0, 8'd0}) begin
            $display("FAIL premid_reset_locked: got %h expected %h", obs(0), {2'd2, 1'b1, 3'b000, 1'b0, 8'd0});
            failures++;
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus_a.state, bus_a.clk_ok, bus_a.fault_cnt} !== 11'h0) begin
            $display("FAIL async_reset_a: got %h expected 000",
                     {bus_a.state, bus_a.clk_ok, bus_a.fault_cnt}); failures++;
        end
        checks++;
        if ({bus_b.state, bus_b.clk_ok} !== 3'b000) begin
            $display("FAIL async_reset_b: got %b expected 000", {bus_b.state, bus_b.clk_ok}); failures++;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs(0) !== 15'h0) begin
            $display("FAIL reset_held: got %h expected %h", obs(0), 15'h0); failures++;
        end
        rst_n = 1'b1;
        model_reset();
        repeat (600) ideal_tick(3'b000, 1'b0);
        checks++;
        if (obs(0) !== mdl(0) || obs(1) !== mdl(1)) begin
            $display("FAIL post_reset_relock: got %h/%h expected %h/%h", obs(0), obs(1), mdl(0), mdl(1));
            failures++;
        end
    endtask

    initial begin
        test_reset();
        test_ideal_lock();
        test_drop_2m();
        test_align();
        test_clr_collision();
        test_saturation();
        test_random();
        test_reset_mid_locked();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench did not complete");
    end

endmodule
`default_nettype wire

// File: doc/ce_monitor.md
CE_MONITOR -- requirements
Module: ce_monitor

Interface
REQ-001 SHALL have parameter LOCK_PERIODS, default 16, meaning consecutive error-free 1.024 MHz periods needed to declare lock (range 1..255).
REQ-002 SHALL have parameter FAULT_CNT_W, default 8, meaning the width of the fault counter.
REQ-003 clk_32d768M  input  1  sole clock; all logic is rising-edge.
REQ-004 rst_n_32d768M  input  1  reset, asynchronous assert, active-low.
REQ-005 ce_16d384M  input  1  clock-enable strobe, nominal period 2 cycles.
REQ-006 ce_2d048M  input  1  clock-enable strobe, nominal period 16 cycles.
REQ-007 ce_1d024M  input  1  clock-enable strobe, nominal period 32 cycles.
REQ-008 err_clr  input  1  single-cycle request to clear the sticky errors and the fault counter.
REQ-009 clk_ok  output  1  high while the FSM is in LOCKED.
REQ-010 err_period  output  3  sticky period errors, where bit0 is 16.384M, bit1 is 2.048M and bit2 is 1.024M.
REQ-011 err_align  output  1  sticky strobe-alignment error.
REQ-012 fault_cnt  output  FAULT_CNT_W  saturating count of FAULT entries.
REQ-013 state  output  2  FSM state for debug: ACQUIRE=0, LOCKING=1, LOCKED=2, FAULT=3.

Function
REQ-014 Each channel SHALL keep a 6-bit counter cnt:
- a strobe cycle sets cnt to 0;
- any other cycle increments cnt, saturating at 63.
REQ-015 Each channel SHALL have an armed flag:
- set on the ce_1d024M strobe that exits ACQUIRE;
- cleared on entry to ACQUIRE.
REQ-016 An armed channel with nominal period P SHALL flag a period error in either case:
- strobe high and cnt != P-1 (early strobe or double pulse);
- strobe low and cnt == P-1 (missing strobe).
REQ-017 In LOCKING and LOCKED, the block SHALL flag an alignment error in either case:
- ce_1d024M high while ce_2d048M or ce_16d384M is low;
- ce_2d048M high while ce_16d384M is low.
REQ-018 Errors detected in ACQUIRE or FAULT SHALL be ignored.
REQ-019 ACQUIRE -> LOCKING on the first cycle in which all three strobes are high together; good_cnt is set to 0 and all channels are armed.
REQ-019a A ce_1d024M strobe without both other strobes SHALL leave the FSM in ACQUIRE.
REQ-020 In LOCKING, each error-free ce_1d024M strobe SHALL increment good_cnt.
REQ-020a When good_cnt reaches LOCK_PERIODS, the FSM SHALL go LOCKING -> LOCKED.
REQ-021 Any error in LOCKING or LOCKED SHALL cause a transition to FAULT, and the error SHALL take priority over lock completion in the same cycle.
REQ-022 FAULT SHALL last exactly one cycle and then return to ACQUIRE.
REQ-023 On entry to FAULT:
- fault_cnt SHALL increment, saturating at all-ones;
- the matching err_period and err_align bits SHALL set.
REQ-024 Latency: a detection at edge N SHALL show on state, clk_ok, the sticky bits and fault_cnt after edge N+1.
REQ-025 clk_ok SHALL be a registered output that is high only in LOCKED.
REQ-026 err_clr SHALL zero err_period, err_align and fault_cnt on the next edge.
REQ-026a If a FAULT entry happens in the same cycle as err_clr, the set SHALL win: the new bits are 1 and fault_cnt is 1.
REQ-027 err_clr SHALL NOT affect the FSM state or the armed flags.

Reset
REQ-028 While rst_n_32d768M is low, the block SHALL hold:
- state=ACQUIRE, clk_ok=0;
- err_period=0, err_align=0, fault_cnt=0;
- all cnt=0, armed=0, good_cnt=0.
REQ-029 Reset asserted mid-LOCKED SHALL drop clk_ok immediately (asynchronously) and SHALL NOT increment fault_cnt.
REQ-030 After reset deasserts, the block SHALL start from ACQUIRE.

Verification
REQ-031 Ideal divider strobes, LOCK_PERIODS=16 -> state 1 after the first common strobe; clk_ok=1 on the cycle after the 16th good ce_1d024M strobe; no errors set.
REQ-032 Locked, then one ce_2d048M pulse dropped -> err_period=3'b010 and fault_cnt=1; state goes 3 then 0 then relocks; clk_ok is low for at least 16x32 cycles.
REQ-033 Locked, then ce_1d024M shifted so it is high without ce_2d048M -> err_align=1, plus err_period[2]=1; fault_cnt=1.
REQ-034 err_clr pulse in the same cycle as a FAULT entry caused by a 16.384M double pulse -> err_period=3'b001, fault_cnt=1; a later lone err_clr pulse -> all 0.
REQ-035 FAULT_CNT_W=2 with 5 forced faults -> fault_cnt saturates at 3.
REQ-036 rst_n_32d768M pulsed low mid-LOCKED -> clk_ok=0 within the same cycle, state=0, fault_cnt unchanged at 0.
